// File: rtl/mfda_seq_pkg.sv
// Shared encodings for the mix stage sequencer: visible phase codes, FSM states
// and the stage-index width helper.
package mfda_seq_pkg;

    typedef enum logic [1:0] {
        PH_IDLE = 2'd0,
        PH_FILL = 2'd1,
        PH_MIX  = 2'd2,
        PH_XFER = 2'd3
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_MIX,
        ST_XFER,
        ST_GAP,
        ST_FIN
    } state_t;

    function automatic int stage_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic state_t phase_state(input phase_t p);
        case (p)
            PH_FILL: return ST_FILL;
            PH_MIX:  return ST_MIX;
            PH_XFER: return ST_XFER;
            default: return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mix_stage_sequencer_if.sv
// Host control / valve-driver bundle of the mix stage sequencer.
// Optional STAGE_PAUSE_EN adds the pause input.
interface mix_stage_sequencer_if
    import mfda_seq_pkg::*;
#(
    parameter int NUM_STAGES = 7,
    parameter int CNT_W      = 16
);
    localparam int SW = stage_w(NUM_STAGES);

    logic                  start;
    logic                  abort;
`ifdef STAGE_PAUSE_EN
    logic                  pause;
`endif
    logic                  cfg_we;
    logic [SW-1:0]         cfg_stage;
    logic [CNT_W-1:0]      cfg_fill;
    logic [CNT_W-1:0]      cfg_mix;
    logic [CNT_W-1:0]      cfg_xfer;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic                  cfg_err;
    logic [SW-1:0]         cur_stage;
    logic [1:0]            phase;
    logic [NUM_STAGES-1:0] inlet_valve;
    logic [NUM_STAGES-1:0] mix_pump;
    logic [NUM_STAGES-1:0] outlet_valve;

    modport master (
        output start, abort,
`ifdef STAGE_PAUSE_EN
        output pause,
`endif
        output cfg_we, cfg_stage, cfg_fill, cfg_mix, cfg_xfer,
        input  busy, done, aborted, cfg_err, cur_stage, phase,
        input  inlet_valve, mix_pump, outlet_valve
    );

    modport slave (
        input  start, abort,
`ifdef STAGE_PAUSE_EN
        input  pause,
`endif
        input  cfg_we, cfg_stage, cfg_fill, cfg_mix, cfg_xfer,
        output busy, done, aborted, cfg_err, cur_stage, phase,
        output inlet_valve, mix_pump, outlet_valve
    );

endinterface

// File: rtl/mix_stage_sequencer_phase_timer.sv
// Down-counter timing one phase: loads N-1, freezes on hold, flags expiry at zero.
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             hold,
    output logic             expired
);
    logic [CNT_W-1:0] value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (!hold && value != '0) begin
            value <= value - CNT_W'(1);
        end
    end

    assign expired = (value == '0);

endmodule

// File: rtl/mix_stage_sequencer.sv
// Fill/mix/transfer sequencer for a row-staged mixer network.
// Optional STAGE_PAUSE_EN freezes the running phase and drops the pump while pause is high.
module mix_stage_sequencer
    import mfda_seq_pkg::*;
#(
    parameter int NUM_STAGES = 7,
    parameter int CNT_W      = 16,
    parameter int FILL_DEF   = 16,
    parameter int MIX_DEF    = 64,
    parameter int XFER_DEF   = 16
) (
    input  logic clk,
    input  logic rst_n,
    mix_stage_sequencer_if.slave bus
);
    localparam int SW = stage_w(NUM_STAGES);

    logic [CNT_W-1:0]      dur_q [NUM_STAGES][3];
    state_t                state_q, state_n;
    logic [SW-1:0]         stage_q, stage_n;
    phase_t                ph_q, ph_n;
    logic                  busy_q, done_q, aborted_q, cfg_err_q;
    logic [1:0]            phase_q;
    logic [NUM_STAGES-1:0] inlet_q, mix_q, outlet_q, stage_oh;

    logic                  nxt_found;
    logic [SW-1:0]         nxt_stage;
    phase_t                nxt_ph;
    logic [CNT_W-1:0]      nxt_len;
    int                    from_lin;
    logic [1:0]            ph_idx;
    logic                  tmr_load, tmr_expired, paused, adv, abort_acc, cfg_bad;
    logic [CNT_W-1:0]      tmr_val;

    assign abort_acc = bus.abort && (state_q != ST_IDLE);
    assign cfg_bad   = busy_q || (int'(bus.cfg_stage) >= NUM_STAGES);
    assign ph_idx    = ph_q - 2'd1;
    assign stage_oh  = NUM_STAGES'(1) << stage_n;

`ifdef STAGE_PAUSE_EN
    assign paused       = bus.pause;
    assign bus.mix_pump = mix_q & {NUM_STAGES{~bus.pause}};
`else
    assign paused       = 1'b0;
    assign bus.mix_pump = mix_q;
`endif
    assign adv = tmr_expired & ~paused;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .hold     (paused),
        .expired  (tmr_expired)
    );

    // Phases are ordered stage*3+phase; the next one to run is the first non-zero duration after the current position.
    assign from_lin = (state_q == ST_IDLE) ? -1 : int'(stage_q) * 3 + int'(ph_q) - 1;

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that skips an assignment would infer a latch.
        nxt_found = 1'b0;
        nxt_stage = '0;
        nxt_ph    = PH_FILL;
        nxt_len   = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            for (int p = 0; p < 3; p++) begin
                if (!nxt_found && (s * 3 + p) > from_lin && dur_q[s][p] != '0) begin
                    nxt_found = 1'b1;
                    nxt_stage = SW'(s);
                    nxt_ph    = phase_t'(2'(p + 1));
                    nxt_len   = dur_q[s][p] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_n  = state_q;
        stage_n  = stage_q;
        ph_n     = ph_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (nxt_found) begin
                        state_n  = phase_state(nxt_ph);
                        stage_n  = nxt_stage;
                        ph_n     = nxt_ph;
                        tmr_load = 1'b1;
                        tmr_val  = nxt_len;
                    end else begin
                        state_n = ST_FIN;
                    end
                end
            end
            ST_FILL, ST_MIX, ST_XFER: begin
                if (adv) begin
                    if (!nxt_found) begin
                        state_n = ST_FIN;
                    end else if (nxt_stage == stage_q) begin
                        state_n  = phase_state(nxt_ph);
                        ph_n     = nxt_ph;
                        tmr_load = 1'b1;
                        tmr_val  = nxt_len;
                    end else begin
                        // Crossing into another stage always costs one dead cycle so valves never overlap.
                        state_n = ST_GAP;
                        stage_n = nxt_stage;
                        ph_n    = nxt_ph;
                    end
                end
            end
            ST_GAP: begin
                state_n  = phase_state(ph_q);
                tmr_load = 1'b1;
                tmr_val  = dur_q[stage_q][ph_idx] - CNT_W'(1);
            end
            default: state_n = ST_IDLE;
        endcase
        if (abort_acc) begin
            state_n  = ST_IDLE;
            tmr_load = 1'b0;
        end
        if (state_n == ST_IDLE) begin
            stage_n = '0;
            ph_n    = PH_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            stage_q   <= '0;
            ph_q      <= PH_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
            phase_q   <= 2'd0;
            inlet_q   <= '0;
            mix_q     <= '0;
            outlet_q  <= '0;
        end else begin
            state_q   <= state_n;
            stage_q   <= stage_n;
            ph_q      <= ph_n;
            busy_q    <= (state_n != ST_IDLE);
            done_q    <= (state_n == ST_FIN);
            aborted_q <= abort_acc;
            cfg_err_q <= bus.cfg_we && cfg_bad;
            phase_q   <= (state_n == ST_FILL || state_n == ST_MIX || state_n == ST_XFER) ? ph_n : PH_IDLE;
            inlet_q   <= (state_n == ST_FILL) ? stage_oh : '0;
            mix_q     <= (state_n == ST_MIX)  ? stage_oh : '0;
            outlet_q  <= (state_n == ST_XFER) ? stage_oh : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the duration table is reset because its defaults are part of the block's behaviour.
            for (int s = 0; s < NUM_STAGES; s++) begin
                dur_q[s][0] <= CNT_W'(FILL_DEF);
                dur_q[s][1] <= CNT_W'(MIX_DEF);
                dur_q[s][2] <= CNT_W'(XFER_DEF);
            end
        end else if (bus.cfg_we && !cfg_bad) begin
            dur_q[bus.cfg_stage][0] <= bus.cfg_fill;
            dur_q[bus.cfg_stage][1] <= bus.cfg_mix;
            dur_q[bus.cfg_stage][2] <= bus.cfg_xfer;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.aborted      = aborted_q;
    assign bus.cfg_err      = cfg_err_q;
    assign bus.cur_stage    = stage_q;
    assign bus.phase        = phase_q;
    assign bus.inlet_valve  = inlet_q;
    assign bus.outlet_valve = outlet_q;

endmodule

// File: tb/tb_mix_stage_sequencer.sv
// Self-checking bench for mix_stage_sequencer: a trace model built from the
// duration table is compared against the outputs every cycle of a run.
module tb_mix_stage_sequencer;
    localparam int NS = 7;
    localparam int CW = 16;

    typedef struct {
        bit busy;
        int ph;
        int stg;
        bit done;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mix_stage_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW)) bus ();

    mix_stage_sequencer #(
        .NUM_STAGES(NS), .CNT_W(CW), .FILL_DEF(16), .MIX_DEF(64), .XFER_DEF(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_cmp = 0;
    int   n_err = 0;
    int   model_dur [NS][3];
    exp_t exp_q [$];
    int   model_len, cyc, done_cyc, done_cnt;
    int   in_cnt [NS];
    int   mix_cnt [NS];
    int   out_cnt [NS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected trace: each non-zero phase for its duration, one dead cycle at every
    // change of stage, then one done cycle and one idle cycle.
    task automatic build_model();
        int last = -1;
        exp_q.delete();
        for (int s = 0; s < NS; s++) begin
            for (int p = 0; p < 3; p++) begin
                if (model_dur[s][p] != 0) begin
                    if (last >= 0 && last != s) exp_q.push_back('{1'b1, 0, s, 1'b0});
                    repeat (model_dur[s][p]) exp_q.push_back('{1'b1, p + 1, s, 1'b0});
                    last = s;
                end
            end
        end
        exp_q.push_back('{1'b1, 0, 0, 1'b1});
        exp_q.push_back('{1'b0, 0, 0, 1'b0});
        model_len = exp_q.size();
    endtask

    always @(negedge clk) begin : compare
        exp_t e;
        logic [NS-1:0] oh;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            oh = NS'(1) << e.stg;
            check($sformatf("c%0d busy", cyc), bus.busy, e.busy);
            check($sformatf("c%0d done", cyc), bus.done, e.done);
            check($sformatf("c%0d phase", cyc), bus.phase, e.ph);
            check($sformatf("c%0d inlet", cyc), bus.inlet_valve, (e.ph == 1) ? oh : '0);
            check($sformatf("c%0d pump", cyc), bus.mix_pump, (e.ph == 2) ? oh : '0);
            check($sformatf("c%0d outlet", cyc), bus.outlet_valve, (e.ph == 3) ? oh : '0);
            check($sformatf("c%0d aborted", cyc), bus.aborted, 0);
            if (e.ph != 0) check($sformatf("c%0d cur_stage", cyc), bus.cur_stage, e.stg);
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            for (int s = 0; s < NS; s++) begin
                in_cnt[s]  += int'(bus.inlet_valve[s]);
                mix_cnt[s] += int'(bus.mix_pump[s]);
                out_cnt[s] += int'(bus.outlet_valve[s]);
            end
        end
    end

    task automatic start_pulse();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic run_sequence(input string tag);
        int guard = 0;
        start_pulse();
        cyc = 0; done_cyc = -1; done_cnt = 0;
        for (int s = 0; s < NS; s++) begin
            in_cnt[s] = 0; mix_cnt[s] = 0; out_cnt[s] = 0;
        end
        build_model();
        while (exp_q.size() > 0 && guard < 5000) begin
            @(posedge clk);
            guard++;
        end
        check({tag, " trace drained"}, exp_q.size(), 0);
        check({tag, " done count"}, done_cnt, 1);
    endtask

    task automatic cfg_write(input int stg, input int f, input int m, input int x);
        @(posedge clk); #1;
        bus.cfg_we = 1'b1; bus.cfg_stage = 3'(stg);
        bus.cfg_fill = CW'(f); bus.cfg_mix = CW'(m); bus.cfg_xfer = CW'(x);
        @(posedge clk); #1 bus.cfg_we = 1'b0;
        check($sformatf("cfg write %0d accepted", stg), bus.cfg_err, 0);
        model_dur[stg][0] = f; model_dur[stg][1] = m; model_dur[stg][2] = x;
    endtask

    task automatic set_defaults();
        for (int s = 0; s < NS; s++) begin
            model_dur[s][0] = 16; model_dur[s][1] = 64; model_dur[s][2] = 16;
        end
    endtask

    task automatic wait_phase(input string tag, input int ph, input int stg);
        int guard = 0;
        while (!(int'(bus.phase) == ph && int'(bus.cur_stage) == stg) && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " reached"}, 32'(guard < 2000), 1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded bound", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int hits;
        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_stage = '0; bus.cfg_fill = '0; bus.cfg_mix = '0; bus.cfg_xfer = '0;
`ifdef STAGE_PAUSE_EN
        bus.pause = 1'b0;
`endif
        set_defaults();
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst aborted", bus.aborted, 0);
        check("rst cfg_err", bus.cfg_err, 0);
        check("rst phase", bus.phase, 0);
        check("rst cur_stage", bus.cur_stage, 0);
        check("rst valves", {bus.inlet_valve, bus.mix_pump, bus.outlet_valve}, 0);

        // Defaults: 97 cycles per stage incl. gap, done on cycle 679.
        run_sequence("dflt");
        check("dflt model length", model_len, 680);
        check("dflt done cycle", done_cyc, 679);
        check("dflt inlet0 cycles", in_cnt[0], 16);
        check("dflt pump0 cycles", mix_cnt[0], 64);
        check("dflt outlet0 cycles", out_cnt[0], 16);
        check("dflt inlet6 cycles", in_cnt[6], 16);

        // Stage 2 mix-only.
        cfg_write(2, 0, 5, 0);
        run_sequence("skip");
        check("skip model length", model_len, 589);
        check("skip done cycle", done_cyc, 588);
        check("skip pump2 cycles", mix_cnt[2], 5);
        check("skip inlet2 cycles", in_cnt[2], 0);
        check("skip outlet2 cycles", out_cnt[2], 0);

        // Every stage zero-length: FIN right after start.
        for (int s = 0; s < NS; s++) cfg_write(s, 0, 0, 0);
        run_sequence("zero");
        check("zero model length", model_len, 2);
        check("zero done cycle", done_cyc, 1);
        for (int s = 0; s < NS; s++) cfg_write(s, 16, 64, 16);

        // abort in IDLE is ignored; start beats abort in the same cycle.
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        check("idle abort ignored", bus.aborted, 0);
        check("idle abort busy", bus.busy, 0);
        @(posedge clk); #1 bus.abort = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0; bus.start = 1'b0;
        check("start wins phase", bus.phase, 1);
        check("start wins inlet", bus.inlet_valve, 7'b0000001);
        check("start wins aborted", bus.aborted, 0);
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        check("abort fill aborted", bus.aborted, 1);
        check("abort fill inlet", bus.inlet_valve, 0);

        // Abort during MIX of stage 3.
        start_pulse();
        wait_phase("mix3", 2, 3);
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        check("abort mix3 aborted", bus.aborted, 1);
        check("abort mix3 valves", {bus.inlet_valve, bus.mix_pump, bus.outlet_valve}, 0);
        check("abort mix3 busy", bus.busy, 0);
        check("abort mix3 done", bus.done, 0);
        hits = 0;
        repeat (20) begin
            @(posedge clk); #1;
            hits += int'(bus.done) + int'(bus.aborted);
        end
        check("abort no done/second pulse", hits, 0);
        run_sequence("restart");
        check("restart done cycle", done_cyc, 679);

        // Rejected config writes: out-of-range stage, and while busy.
        @(posedge clk); #1;
        bus.cfg_we = 1'b1; bus.cfg_stage = 3'd7; bus.cfg_fill = 16'd1;
        bus.cfg_mix = 16'd1; bus.cfg_xfer = 16'd1;
        @(posedge clk); #1 bus.cfg_we = 1'b0;
        check("cfg range err", bus.cfg_err, 1);
        @(posedge clk); #1;
        check("cfg range err pulse", bus.cfg_err, 0);
        start_pulse();
        repeat (3) @(posedge clk);
        #1 bus.cfg_we = 1'b1; bus.cfg_stage = 3'd1; bus.cfg_fill = 16'd3;
        @(posedge clk); #1 bus.cfg_we = 1'b0;
        check("cfg busy err", bus.cfg_err, 1);
        @(posedge clk); #1;
        check("cfg busy err pulse", bus.cfg_err, 0);
        bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        run_sequence("after_err");
        check("after_err done cycle", done_cyc, 679);

        // Asynchronous reset mid-FILL of stage 1 restores default durations.
        cfg_write(0, 2, 2, 2);
        start_pulse();
        wait_phase("fill1", 1, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("async rst valves", {bus.inlet_valve, bus.mix_pump, bus.outlet_valve}, 0);
        check("async rst busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_defaults();
        run_sequence("post_rst");
        check("post_rst done cycle", done_cyc, 679);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
